// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;

    // Bits needed to hold the iteration count DIVIDEND_W down to 1.
    function automatic int cnt_w(input int dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it fits.
// The remainder is carried in DIVISOR_W bits: T-D < D and T < D both fit,
// so the extra bit of T only matters for the compare.
module div_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W-1:0] i_r,
    input  logic                 i_bit,
    input  logic [DIVISOR_W:0]   i_d,
    output logic [DIVISOR_W-1:0] o_r,
    output logic                 o_qbit
);

    logic [DIVISOR_W:0] w_t;

    assign w_t = {i_r, i_bit};

    // Trial subtract and restore select.
    always_comb begin
        o_qbit = (w_t >= i_d);
        o_r    = o_qbit ? DIVISOR_W'(w_t - i_d) : w_t[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_EN: a zero divisor skips iteration and reports
// div_zero with quotient all ones and remainder 0. Without it the algorithm
// runs normally on a zero divisor and o_div_zero stays 0.
module seq_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DIVIDEND_W-1:0] o_quotient,
    output logic [DIVISOR_W-1:0]  o_remainder,
    output logic                  o_div_zero
);

    localparam int               CNT_W    = cnt_w(DIVIDEND_W);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                r_state;
    logic [DIVISOR_W-1:0]  r_d;
    logic [DIVISOR_W-1:0]  r_r;
    logic [DIVIDEND_W-1:0] r_q;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_zero;

    logic [DIVISOR_W-1:0]  w_r_next;
    logic                  w_qbit;
    logic [DIVIDEND_W-1:0] w_q_next;
    logic                  w_zero_skip;

    div_step #(
        .DIVISOR_W(DIVISOR_W)
    ) u_step (
        .i_r   (r_r),
        .i_bit (r_q[DIVIDEND_W-1]),
        .i_d   ({1'b0, r_d}),
        .o_r   (w_r_next),
        .o_qbit(w_qbit)
    );

    assign w_q_next = {r_q[DIVIDEND_W-2:0], w_qbit};

`ifdef DIV_ZERO_EN
    assign w_zero_skip = (i_divisor == '0);
`else
    assign w_zero_skip = 1'b0;
`endif

    // Controller: accept in IDLE/DONE, iterate in RUN, publish results on entry to DONE.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state     <= IDLE;
            r_d         <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RUN: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    if (i_start) begin
                        r_div_zero <= w_zero_skip;
                        if (w_zero_skip) begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= '0;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_d     <= i_divisor;
                            r_q     <= i_dividend;
                            r_r     <= '0;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;
    assign o_div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider with a behavioural reference model.
// Build with +define+DIV_ZERO_EN to exercise the divide-by-zero shortcut.
module tb_seq_divider;

    localparam int DW  = 8;
    localparam int VW  = 4;
    localparam int LAT = DW;  // edges from accept edge to the edge that raises done

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          busy, done, div_zero;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .i_sys_clk  (clk),
        .i_sys_rst  (rst),
        .i_start    (start),
        .i_dividend (dividend),
        .i_divisor  (divisor),
        .o_busy     (busy),
        .o_done     (done),
        .o_quotient (quotient),
        .o_remainder(remainder),
        .o_div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    // Reference arithmetic for one division.
    function automatic void ref_div(input int a, input int b,
                                    output logic [DW-1:0] q, output logic [VW-1:0] r,
                                    output bit dz);
        if (b == 0) begin
`ifdef DIV_ZERO_EN
            q = '1; r = '0; dz = 1'b1;
`else
            q = '1; r = VW'(a % (1 << VW)); dz = 1'b0;
`endif
        end else begin
            q = DW'(a / b); r = VW'(a % b); dz = 1'b0;
        end
    endfunction

    // Model: an operation is either in flight with a known completion edge or not.
    bit            m_active, m_busy, m_done, m_dz, p_dz;
    int            m_done_edge;
    logic [DW-1:0] m_q, p_q;
    logic [VW-1:0] m_r, p_r;

    always @(posedge clk) begin
        bit acc;
        cyc++;
        if (rst) begin
            m_active = 0; m_busy = 0; m_done = 0;
            m_q = '0; m_r = '0; m_dz = 0;
        end else begin
            acc    = start && !m_active;
            m_done = 0;
            if (m_active && cyc == m_done_edge) begin
                m_active = 0; m_done = 1; m_q = p_q; m_r = p_r;
            end
            if (acc) begin
                ref_div(int'(dividend), int'(divisor), p_q, p_r, p_dz);
`ifdef DIV_ZERO_EN
                if (divisor == '0) begin
                    m_done = 1; m_q = p_q; m_r = p_r; m_dz = 1;
                end else
`endif
                begin
                    m_active = 1; m_done_edge = cyc + LAT; m_dz = 0;
                end
            end
            m_busy = m_active;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(posedge clk) begin
        #1;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("quotient", 32'(quotient), 32'(m_q));
        chk("remainder", 32'(remainder), 32'(m_r));
        chk("div_zero", 32'(div_zero), 32'(m_dz));
    end

    // Wait for done with a bound; returns edges since t0 (large on timeout).
    task automatic wait_done(input int t0, output int lat);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        lat = (done === 1'b1) ? (cyc - t0) : 999;
    endtask

    // Start one division; optionally keep start high (with junk operands) during RUN.
    task automatic run_op(input int a, input int b, input int hold, output int lat, output int t0);
        @(negedge clk);
        start = 1'b1; dividend = DW'(a); divisor = VW'(b);
        @(posedge clk); #1;
        t0 = cyc;
        for (int i = 0; i < hold; i++) begin
            dividend = DW'($urandom); divisor = VW'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_done(t0, lat);
    endtask

    task automatic op_lit(input string nm, input int a, input int b,
                          input int eq, input int er, input int edz, input int elat);
        int lat, t0;
        run_op(a, b, 0, lat, t0);
        chk({nm, "_q"}, 32'(quotient), 32'(eq));
        chk({nm, "_r"}, 32'(remainder), 32'(er));
        chk({nm, "_dz"}, 32'(div_zero), 32'(edz));
        chk({nm, "_lat"}, 32'(lat), 32'(elat));
    endtask

    initial begin
        int lat, t0, t1, dn;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        bit dz;

        // Pin the model with hand-computed values.
        ref_div(200, 7, q, r, dz);
        chk("model_200_7_q", 32'(q), 28);
        chk("model_200_7_r", 32'(r), 4);
        ref_div(77, 6, q, r, dz);
        chk("model_77_6", {24'd0, q[3:0], r}, {24'd0, 4'd12, 4'd5});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_q", 32'(quotient), 0);
        chk("rst_r", 32'(remainder), 0);
        @(negedge clk); rst = 1'b0;

        // Reset during RUN aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_q", 32'(quotient), 0);
        chk("abort_r", 32'(remainder), 0);
        dn = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) dn++;
        end
        chk("abort_no_done", 32'(dn), 0);

        op_lit("d200_7", 200, 7, 28, 4, 0, LAT);
        op_lit("d255_15", 255, 15, 17, 0, 0, LAT);
        op_lit("d5_9", 5, 9, 0, 5, 0, LAT);
        op_lit("d120_8", 120, 8, 15, 0, 0, LAT);
        op_lit("d0_3", 0, 3, 0, 0, 0, LAT);
`ifdef DIV_ZERO_EN
        op_lit("d13_0", 13, 0, 255, 0, 1, 0);
        op_lit("d9_2_after_zero", 9, 2, 4, 1, 0, LAT);
`else
        op_lit("d13_0", 13, 0, 255, 13, 0, LAT);
`endif

        // start held high during RUN is ignored.
        run_op(50, 6, 5, lat, t0);
        chk("hold_q", 32'(quotient), 8);
        chk("hold_r", 32'(remainder), 2);
        chk("hold_lat", 32'(lat), LAT);

        // Back-to-back: accept while in DONE.
        run_op(100, 3, 0, lat, t0);
        chk("b2b1_q", 32'(quotient), 33);
        chk("b2b1_r", 32'(remainder), 1);
        start = 1'b1; dividend = 8'd77; divisor = 4'd6;
        @(posedge clk); #1; start = 1'b0;
        t1 = cyc;
        chk("b2b_no_gap_busy", 32'(busy), 1);
        chk("b2b_spacing", 32'(t1 - t0), LAT + 1);
        wait_done(t1, lat);
        chk("b2b2_q", 32'(quotient), 12);
        chk("b2b2_r", 32'(remainder), 5);
        chk("b2b2_lat", 32'(lat), LAT);

        // Full sweep of nonzero divisors with random gaps and random start holds.
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                repeat ($urandom_range(0, 1)) @(posedge clk);
                run_op(a, b, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0, lat, t0);
                chk("sweep_lat", 32'(lat), LAT);
            end
        end

        // A few random operands including zero divisors.
        repeat (40) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 0, lat, t0);
        end

        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
